// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of an 8N1/8N2 serializer.
// The fractional-accumulator baud generator is phase-reset while idle, and queued bytes go out back-to-back.
module uart_tx_fifo #(
   parameter int ClkFrequency          = 10000000,
   parameter int Baud                  = 115200,
   parameter int BaudGeneratorAccWidth = 16,
   parameter int FifoDepthLog2         = 3,
   parameter int StopBits              = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic       tx_overflow,
   output logic       TxD,
   output logic       TxD_busy,
   output logic       TxD_done
);
   localparam int W = BaudGeneratorAccWidth;
   localparam int Depth = 1 << FifoDepthLog2;
   localparam longint IncL =
      ((longint'(Baud) << (W - 4)) + longint'(ClkFrequency >> 5)) / longint'(ClkFrequency >> 4);
   localparam logic [W:0] Inc = (W + 1)'(IncL);
   localparam logic [FifoDepthLog2:0] DepthCnt = (FifoDepthLog2 + 1)'(Depth);

   typedef enum logic [3:0] {
      sIdle, sStart, sD0, sD1, sD2, sD3, sD4, sD5, sD6, sD7, sStop1, sStop2
   } state_t;

   state_t                   state;
   logic [7:0]               mem [Depth];
   logic [FifoDepthLog2-1:0] wrPtr, rdPtr;
   logic [FifoDepthLog2:0]   count;
   logic [7:0]               shifter;
   logic [W-1:0]             accReg;
   logic [W:0]               acc;
   logic                     baudTick, lastStop, frameEnd, push, pop;

   assign fifo_full  = (count == DepthCnt);
   assign fifo_empty = (count == '0);
   assign push       = wr_en & ~fifo_full;

   // Tick is the carry of the sum being registered, so every bit is exactly one tick period long.
   assign acc      = {1'b0, accReg} + Inc;
   assign baudTick = acc[W] & (state != sIdle);
   assign lastStop = (StopBits == 2) ? (state == sStop2) : (state == sStop1);
   assign frameEnd = lastStop & baudTick;
   assign pop      = ~fifo_empty & ((state == sIdle) | frameEnd);

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= wr_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= sIdle;
         wrPtr       <= '0;
         rdPtr       <= '0;
         count       <= '0;
         shifter     <= '0;
         accReg      <= '0;
         TxD         <= 1'b1;
         TxD_busy    <= 1'b0;
         TxD_done    <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         tx_overflow <= wr_en & fifo_full;
         TxD_done    <= 1'b0;
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (state == sIdle) begin
            accReg <= '0;
            if (pop) begin
               shifter  <= mem[rdPtr];
               state    <= sStart;
               TxD      <= 1'b0;
               TxD_busy <= 1'b1;
            end
         end else begin
            accReg <= acc[W-1:0];
            if (frameEnd) begin
               TxD_done <= 1'b1;
               if (pop) begin
                  shifter <= mem[rdPtr];
                  state   <= sStart;
                  TxD     <= 1'b0;
               end else begin
                  state    <= sIdle;
                  TxD      <= 1'b1;
                  TxD_busy <= 1'b0;
               end
            end else if (baudTick) begin
               state <= state_t'(state + 4'd1);
               if (state >= sStart && state <= sD6) begin
                  TxD     <= shifter[0];
                  shifter <= shifter >> 1;
               end else begin
                  TxD <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 16-clk/bit instances (1 and 2 stop bits) plus a default-rate loopback.
module tb_uart_tx_fifo;
   logic clk, resetn;
   logic wrA, wrB, wrC;
   logic [7:0] dataA, dataB, dataC;
   logic fullA, emptyA, ovfA, txdA, busyA, doneA;
   logic fullB, emptyB, ovfB, txdB, busyB, doneB;
   logic fullC, emptyC, ovfC, txdC, busyC, doneC;
   int checks = 0;
   int failures = 0;

   uart_tx_fifo #(.ClkFrequency(1843200), .Baud(115200), .BaudGeneratorAccWidth(16),
                  .FifoDepthLog2(3), .StopBits(1)) dutA (
      .clk(clk), .resetn(resetn), .wr_en(wrA), .wr_data(dataA), .fifo_full(fullA),
      .fifo_empty(emptyA), .tx_overflow(ovfA), .TxD(txdA), .TxD_busy(busyA), .TxD_done(doneA));

   uart_tx_fifo #(.ClkFrequency(1843200), .Baud(115200), .BaudGeneratorAccWidth(16),
                  .FifoDepthLog2(3), .StopBits(2)) dutB (
      .clk(clk), .resetn(resetn), .wr_en(wrB), .wr_data(dataB), .fifo_full(fullB),
      .fifo_empty(emptyB), .tx_overflow(ovfB), .TxD(txdB), .TxD_busy(busyB), .TxD_done(doneB));

   uart_tx_fifo dutC (
      .clk(clk), .resetn(resetn), .wr_en(wrC), .wr_data(dataC), .fifo_full(fullC),
      .fifo_empty(emptyC), .tx_overflow(ovfC), .TxD(txdC), .TxD_busy(busyC), .TxD_done(doneC));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Entered at the START edge (minus skip cycles already elapsed); leaves at the frame-end edge.
   task automatic checkFrame(input int sel, input logic [7:0] d, input int nStop,
                             input int skip, input logic busyAfter);
      logic [11:0] bits;
      int nbits;
      bits  = {2'b11, 1'b1, d, 1'b0};
      nbits = 9 + nStop;
      for (int i = 0; i < nbits; i++) begin
         chk($sformatf("bit%0d_start", i), (sel == 0) ? txdA : txdB, bits[i]);
         tick(15 - ((i == 0) ? skip : 0));
         chk($sformatf("bit%0d_end", i), (sel == 0) ? txdA : txdB, bits[i]);
         tick(1);
      end
      chk("done_pulse", (sel == 0) ? doneA : doneB, 1'b1);
      chk("busy_after", (sel == 0) ? busyA : busyB, busyAfter);
      if (!busyAfter) chk("idle_line", (sel == 0) ? txdA : txdB, 1'b1);
   endtask

   initial begin
      int n, bad, len, t, k, readyCnt;
      int samp [10];
      logic [9:0] rx;
      resetn = 1'b0;
      wrA = 0; wrB = 0; wrC = 0;
      dataA = 0; dataB = 0; dataC = 0;
      tick(3);
      chk("rst_txd", txdA, 1'b1);
      chk("rst_busy", busyA, 1'b0);
      chk("rst_done", doneA, 1'b0);
      chk("rst_ovf", ovfA, 1'b0);
      chk("rst_empty", emptyA, 1'b1);
      chk("rst_full", fullA, 1'b0);
      resetn = 1'b1;
      tick(5);

      // single byte
      wrA = 1; dataA = 8'h55;
      tick(1);
      wrA = 0;
      chk("t1_empty_after_wr", emptyA, 1'b0);
      chk("t1_still_idle", txdA, 1'b1);
      tick(1);
      chk("t1_busy_rise", busyA, 1'b1);
      chk("t1_popped", emptyA, 1'b1);
      checkFrame(0, 8'h55, 1, 0, 1'b0);
      tick(1);
      chk("t1_done_width", doneA, 1'b0);
      tick(10);

      // burst of three, back-to-back
      wrA = 1; dataA = 8'h00;
      tick(1);
      dataA = 8'hFF;
      tick(1);
      dataA = 8'hA5;
      tick(1);
      wrA = 0;
      checkFrame(0, 8'h00, 1, 1, 1'b1);
      chk("t2_one_left", emptyA, 1'b0);
      checkFrame(0, 8'hFF, 1, 0, 1'b1);
      chk("t2_empty_after_3rd_pop", emptyA, 1'b1);
      checkFrame(0, 8'hA5, 1, 0, 1'b0);
      tick(10);

      // overflow: ten writes, one dropped
      n = 0;
      for (int i = 0; i < 10; i++) begin
         wrA = 1; dataA = 8'(i + 1);
         tick(1);
         if (ovfA) n++;
         if (i == 7) chk("t3_not_full_7", fullA, 1'b0);
         if (i == 8) chk("t3_full_8", fullA, 1'b1);
         if (i == 9) chk("t3_ovf_pulse", ovfA, 1'b1);
      end
      wrA = 0;
      tick(1);
      if (ovfA) n++;
      chk("t3_ovf_count", n, 1);
      chk("t3_still_full", fullA, 1'b1);
      n = 0;
      for (int i = 0; i < 1500; i++) begin
         tick(1);
         if (doneA) n++;
      end
      chk("t3_frames", n, 9);
      chk("t3_idle_busy", busyA, 1'b0);
      chk("t3_idle_empty", emptyA, 1'b1);

      // reset during D3
      wrA = 1; dataA = 8'hF0;
      tick(1);
      dataA = 8'h11;
      tick(1);
      dataA = 8'h22;
      tick(1);
      wrA = 0;
      tick(70);
      chk("t4_in_d3_low", txdA, 1'b0);
      #3 resetn = 1'b0;
      #1;
      chk("t4_async_txd", txdA, 1'b1);
      chk("t4_async_busy", busyA, 1'b0);
      chk("t4_async_empty", emptyA, 1'b1);
      tick(3);
      resetn = 1'b1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (txdA !== 1'b1 || busyA !== 1'b0) bad++;
      end
      chk("t4_stays_idle", bad, 0);

      // two stop bits
      wrB = 1; dataB = 8'h81;
      tick(1);
      wrB = 0;
      tick(1);
      chk("t5_busy", busyB, 1'b1);
      checkFrame(1, 8'h81, 2, 0, 1'b0);

      // default rate, loopback into a sampling receiver model
      for (int i = 0; i < 10; i++) samp[i] = ((2 * i + 1) * 868) / 20;
      wrC = 1; dataC = 8'hC3;
      tick(1);
      wrC = 0;
      t = 0;
      while (txdC !== 1'b0 && t < 5) begin
         tick(1);
         t++;
      end
      chk("t6_start_seen", txdC, 1'b0);
      len = -1; k = 0; rx = '1;
      for (t = 1; t <= 1000; t++) begin
         tick(1);
         if (k < 10 && t == samp[k]) begin
            rx[k] = txdC;
            k++;
         end
         if (doneC === 1'b1) begin
            len = t;
            break;
         end
      end
      readyCnt = (rx[0] == 1'b0 && rx[9] == 1'b1 && k == 10) ? 1 : 0;
      chk("t6_rx_data", rx[8:1], 8'hC3);
      chk("t6_rx_ready", readyCnt, 1);
      chk("t6_frame_len_ok", (len >= 866 && len <= 870) ? 1 : 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
